// File: rtl/mips_muldiv_if.sv
// Request/response bundle between the execute stage and the mult/div sequencer.
interface mips_muldiv_if #(
  parameter int XLEN = 32
);
  logic            op_valid;
  logic [2:0]      op_code;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            op_ready;
  logic            mf_req;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output op_valid, op_code, rs_data, rt_data, mf_req,
    input  op_ready, stall, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op_code, rs_data, rt_data, mf_req,
    output op_ready, stall, busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_ctrl.sv
// MIPS multiply/divide sequencer: iterative shift-add multiply and restoring
// divide (one bit per cycle), sign fix-up cycle, and the HI/LO registers.
module mips_muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  mips_muldiv_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;  // negate product / quotient
  logic              neg_hi_q, neg_hi_d;  // negate remainder
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              op_signed, rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;

  assign op_signed = (bus.op_code == 3'd0) || (bus.op_code == 3'd2);
  assign rs_neg    = op_signed & bus.rs_data[XLEN-1];
  assign rt_neg    = op_signed & bus.rt_data[XLEN-1];
  assign rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;

  // One shift-add step: add multiplicand when the current multiplier bit is set.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // One restoring step: the extra top bit keeps the borrow unambiguous.
  assign rem_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = {1'b0, rem_shift} - {2'b00, opnd_q};
  assign div_ge    = ~div_diff[XLEN+1];
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : rem_shift[XLEN-1:0];

  assign bus.op_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.stall    = (bus.mf_req | bus.op_valid) & bus.busy;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // Next-state and datapath step for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          case (bus.op_code)
            3'd0, 3'd1: begin
              acc_d    = {{XLEN{1'b0}}, rt_mag};
              opnd_d   = rs_mag;
              neg_lo_d = rs_neg ^ rt_neg;
              neg_hi_d = rs_neg ^ rt_neg;
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            3'd2, 3'd3: begin
              is_div_d = 1'b1;
              cnt_d    = '0;
              if (bus.rt_data == '0) begin
                // Divide by zero skips iteration; FIX commits raw rs and all ones.
                acc_d    = {bus.rs_data, {XLEN{1'b1}}};
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
                state_d  = S_FIX;
              end else begin
                acc_d    = {{XLEN{1'b0}}, rs_mag};
                opnd_d   = rt_mag;
                neg_lo_d = rs_neg ^ rt_neg;
                neg_hi_d = rs_neg;
                state_d  = S_DIV;
              end
            end
            3'd4:    hi_d = bus.rs_data;
            3'd5:    lo_d = bus.rs_data;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_DIV: begin
        acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      default: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          hi_d = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Bench for mips_muldiv_ctrl: directed table, random ops against an
// arithmetic reference model, stall and asynchronous-reset sequences.
module tb_mips_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_muldiv_if #(.XLEN(32)) bus ();
  mips_muldiv_ctrl #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t vecs[12];

  logic [31:0] hi_m, lo_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result computed with plain arithmetic.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] h_in, input logic [31:0] l_in,
                        output logic [31:0] h, output logic [31:0] l);
    longint a, b;
    logic [63:0] p, ua, ub;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    h = h_in;
    l = l_in;
    case (op)
      3'd0: begin p = 64'(a * b); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (rt == 0) begin h = rs; l = 32'hFFFF_FFFF; end
        else begin p = 64'(a / b); l = p[31:0]; p = 64'(a % b); h = p[31:0]; end
      end
      3'd3: begin
        if (rt == 0) begin h = rs; l = 32'hFFFF_FFFF; end
        else begin l = rs / rt; h = rs % rt; end
      end
      3'd4: h = rs;
      3'd5: l = rs;
      default: ;
    endcase
  endtask

  // Issue one op (entered and left just after a rising edge) and check its outcome.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] eh, input logic [31:0] el);
    int lat;
    int exp_lat;
    bit busy_ok;
    chk("ready_before_op", 64'(bus.op_ready), 64'd1);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    lat = 0;
    if (op < 3'd4) begin
      exp_lat = (op >= 3'd2 && rt == 0) ? 1 : 33;
      busy_ok = 1'b1;
      while (!bus.done && lat < 40) begin
        if (!bus.busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("busy_during_op", 64'(busy_ok), 64'd1);
      chk("busy_in_done_cycle", 64'(bus.busy), 64'd0);
      chk("ready_in_done_cycle", 64'(bus.op_ready), 64'd1);
    end else begin
      chk("move_busy", 64'(bus.busy), 64'd0);
      chk("move_done", 64'(bus.done), 64'd0);
    end
    chk("hi", 64'(bus.hi), 64'(eh));
    chk("lo", 64'(bus.lo), 64'(el));
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h lat=%0d", op, rs, rt, bus.hi, bus.lo, lat);
  endtask

  initial begin
    int stall_cnt, lat;
    bit done_seen;
    logic [2:0]  op;
    logic [31:0] rs, rt, eh, el;

    vecs[0]  = '{3'd0, 32'd10,        32'hFFFF_FFF6, 32'hFFFF_FFFF, 32'hFFFF_FF9C};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd4, 32'h0000_A5A5, 32'd0,         32'h0000_A5A5, 32'hFFFF_FFFF};
    vecs[7]  = '{3'd5, 32'h0000_005A, 32'd9,         32'h0000_A5A5, 32'h0000_005A};
    vecs[8]  = '{3'd6, 32'h1111_1111, 32'd3,         32'h0000_A5A5, 32'h0000_005A};
    vecs[9]  = '{3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[10] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[11] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    rst = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
    bus.rs_data  = '0;
    bus.rt_data  = '0;
    bus.mf_req   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_ready", 64'(bus.op_ready), 64'd1);
    chk("reset_stall", 64'(bus.stall), 64'd0);
    bus.mf_req = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);
    hi_m = vecs[11].hi;
    lo_m = vecs[11].lo;

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom;
      rt = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rt = 32'($urandom_range(1, 9));
      ref_op(op, rs, rt, hi_m, lo_m, eh, el);
      run_op(op, rs, rt, eh, el);
      hi_m = eh;
      lo_m = el;
    end

    // MULT in flight with mfhi and a queued MTLO: stall until the done cycle.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd0;
    bus.rs_data  = 32'd3;
    bus.rt_data  = 32'd5;
    @(posedge clk); #1;
    bus.op_code  = 3'd5;
    bus.rs_data  = 32'd7;
    bus.mf_req   = 1'b1;
    stall_cnt = 0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      if (bus.stall) stall_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_cycles", 64'(stall_cnt), 64'd33);
    chk("stall_in_done_cycle", 64'(bus.stall), 64'd0);
    chk("lo_before_mtlo", 64'(bus.lo), 64'd15);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.mf_req   = 1'b0;
    chk("lo_after_mtlo", 64'(bus.lo), 64'd7);
    chk("hi_after_mtlo", 64'(bus.hi), 64'd0);
    chk("busy_after_mtlo", 64'(bus.busy), 64'd0);
    $display("stall seq: stall_cycles=%0d lo=%h", stall_cnt, bus.lo);

    // Asynchronous reset in the middle of a DIV.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd2;
    bus.rs_data  = 32'd100;
    bus.rt_data  = 32'd7;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_hi", 64'(bus.hi), 64'd0);
    chk("async_rst_lo", 64'(bus.lo), 64'd0);
    chk("async_rst_ready", 64'(bus.op_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      if (bus.done) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("no_done_after_rst", 64'(done_seen), 64'd0);
    $display("reset seq: hi=%h lo=%h done_seen=%0d", bus.hi, bus.lo, done_seen);
    run_op(3'd0, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
